// File: rtl/timer_expiry_queue_pkg.sv
// Shared widths and defaults for the timer expiry queue.
// Optional latency monitor: TMR_EXPIRY_LATENCY_EN (see timer_expiry_queue.sv).
package timers_pkg;

  localparam int lp_ADDRESS_WIDTH = 32;
  localparam int lp_TICK_WIDTH    = 32;
  localparam int lp_DEPTH         = 16;
  localparam int lp_PTR_W         = $clog2(lp_DEPTH) + 1;
  localparam int lp_LATE_LIMIT    = 4;

  // Pointer width for a power-of-two queue: one extra bit tells full from empty
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/timer_expiry_queue_if.sv
// Show-ahead event port between the expiry queue (master) and the timer service (slave).
// Optional feature macro TMR_EXPIRY_LATENCY_EN does not change this interface.
interface timer_expiry_queue_if #(
  parameter int C_ADDRESS_WIDTH = 32,
  parameter int C_TICK_WIDTH    = 32
);
  logic                       evtValid_out;
  logic                       evtReady_in;
  logic [C_ADDRESS_WIDTH-1:0] evtPointer_out;
  logic [C_TICK_WIDTH-1:0]    evtTick_out;

  modport master (output evtValid_out, evtPointer_out, evtTick_out, input evtReady_in);
  modport slave  (input evtValid_out, evtPointer_out, evtTick_out, output evtReady_in);
endinterface

// File: rtl/timer_expiry_queue_ram.sv
// tmr_evt_ram: distributed event store, synchronous write and asynchronous read.
// Unaffected by TMR_EXPIRY_LATENCY_EN.
module tmr_evt_ram #(
  parameter int C_DEPTH = 16,
  parameter int C_WIDTH = 64
) (
  input  logic                       aclk,
  input  logic                       we,
  input  logic [$clog2(C_DEPTH)-1:0] waddr,
  input  logic [C_WIDTH-1:0]         wdata,
  input  logic [$clog2(C_DEPTH)-1:0] raddr,
  output logic [C_WIDTH-1:0]         rdata
);

  logic [C_WIDTH-1:0] mem_r [C_DEPTH];

  // Write port
  always_ff @(posedge aclk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/timer_expiry_queue.sv
// Expiry-event FIFO with drop accounting and threshold IRQ.
// Macro TMR_EXPIRY_LATENCY_EN adds evtLate_out/lateFlag_out latency monitoring.
module timer_expiry_queue
  import timers_pkg::*;
#(
  parameter int C_ADDRESS_WIDTH = lp_ADDRESS_WIDTH,
  parameter int C_TICK_WIDTH    = lp_TICK_WIDTH,
  parameter int C_DEPTH         = lp_DEPTH,
  parameter int C_IRQ_THRESH    = 1,
`ifdef TMR_EXPIRY_LATENCY_EN
  parameter int C_LATE_LIMIT    = lp_LATE_LIMIT,
`endif
  parameter int C_DROP_WIDTH    = 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       expire_in,
  input  logic [C_ADDRESS_WIDTH-1:0] expPointer_in,
  input  logic [C_TICK_WIDTH-1:0]    tick_in,
  input  logic                       flush_in,
  input  logic                       ovfClr_in,
  timer_expiry_queue_if.master       evt,
`ifdef TMR_EXPIRY_LATENCY_EN
  output logic [C_TICK_WIDTH-1:0]    evtLate_out,
  output logic                       lateFlag_out,
`endif
  output logic [$clog2(C_DEPTH):0]   count_out,
  output logic                       irq_out,
  output logic                       ovf_out,
  output logic [C_DROP_WIDTH-1:0]    dropCnt_out
);

  localparam int lp_PW = ptr_width(C_DEPTH);
  localparam int lp_AW = lp_PW - 1;
  localparam int lp_EW = C_ADDRESS_WIDTH + C_TICK_WIDTH;
  localparam logic [lp_PW-1:0] lp_ONE = lp_PW'(1);
  localparam logic [lp_PW-1:0] lp_THRESH = lp_PW'(C_IRQ_THRESH);
  localparam logic [C_DROP_WIDTH-1:0] lp_DROP_MAX = {C_DROP_WIDTH{1'b1}};

  logic [lp_PW-1:0]        wr_ptr_r, rd_ptr_r, count_r;
  logic [lp_PW-1:0]        wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
  logic                    irq_r, ovf_r, ovf_nxt_s;
  logic [C_DROP_WIDTH-1:0] drop_cnt_r, drop_cnt_nxt_s;
  logic                    full_s, empty_s, pop_s, push_s, drop_s, we_s;
  logic [lp_EW-1:0]        rdata_s;

  assign full_s  = (wr_ptr_r[lp_PW-1] != rd_ptr_r[lp_PW-1]) &&
                   (wr_ptr_r[lp_AW-1:0] == rd_ptr_r[lp_AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign pop_s   = !empty_s && evt.evtReady_in;
  assign push_s  = expire_in && (!full_s || pop_s);
  // A push swallowed by flush is neither stored nor counted as a drop
  assign drop_s  = expire_in && full_s && !pop_s && !flush_in;
  assign we_s    = push_s && !flush_in;

  tmr_evt_ram #(
    .C_DEPTH (C_DEPTH),
    .C_WIDTH (lp_EW)
  ) u_ram (
    .aclk  (aclk),
    .we    (we_s),
    .waddr (wr_ptr_r[lp_AW-1:0]),
    .wdata ({expPointer_in, tick_in}),
    .raddr (rd_ptr_r[lp_AW-1:0]),
    .rdata (rdata_s)
  );

  assign evt.evtValid_out   = !empty_s;
  assign evt.evtPointer_out = rdata_s[lp_EW-1:C_TICK_WIDTH];
  assign evt.evtTick_out    = rdata_s[C_TICK_WIDTH-1:0];

  // Next pointers: flush overrides both push and pop
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (flush_in) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + lp_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + lp_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // Overflow bookkeeping: a drop outranks a same-cycle clear
  always_comb begin
    ovf_nxt_s      = ovf_r;
    drop_cnt_nxt_s = drop_cnt_r;
    if (drop_s) begin
      ovf_nxt_s = 1'b1;
      if (ovfClr_in) begin
        drop_cnt_nxt_s = {{(C_DROP_WIDTH-1){1'b0}}, 1'b1};
      end else if (drop_cnt_r != lp_DROP_MAX) begin
        drop_cnt_nxt_s = drop_cnt_r + {{(C_DROP_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_nxt_s = drop_cnt_r;
      end
    end else if (ovfClr_in) begin
      ovf_nxt_s      = 1'b0;
      drop_cnt_nxt_s = '0;
    end else begin
      ovf_nxt_s      = ovf_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // State registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      irq_r      <= 1'b0;
      ovf_r      <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      irq_r      <= (count_nxt_s >= lp_THRESH);
      ovf_r      <= ovf_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  assign count_out   = count_r;
  assign irq_out     = irq_r;
  assign ovf_out     = ovf_r;
  assign dropCnt_out = drop_cnt_r;

`ifdef TMR_EXPIRY_LATENCY_EN
  logic late_flag_r;

  // Modular difference stays correct across tick counter wrap
  assign evtLate_out = tick_in - evt.evtTick_out;

  // Sticky late flag; a late pop outranks a same-cycle clear
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      late_flag_r <= 1'b0;
    end else if (pop_s && !flush_in && (evtLate_out > C_TICK_WIDTH'(C_LATE_LIMIT))) begin
      late_flag_r <= 1'b1;
    end else if (ovfClr_in) begin
      late_flag_r <= 1'b0;
    end else begin
      late_flag_r <= late_flag_r;
    end
  end

  assign lateFlag_out = late_flag_r;
`endif

endmodule

// File: tb/tb_timer_expiry_queue.sv
// Directed bench for timer_expiry_queue: default instance plus a DEPTH=4/THRESH=4 instance.
// Latency checks run only when TMR_EXPIRY_LATENCY_EN is defined.
module tb_timer_expiry_queue;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // dut1: defaults (DEPTH 16, THRESH 1, DROP 8)
  logic        expire1 = 1'b0, flush1 = 1'b0, clr1 = 1'b0;
  logic [31:0] ptr1 = 32'h0, tick1 = 32'h0;
  logic [4:0]  count1;
  logic        irq1, ovf1;
  logic [7:0]  drop1;
`ifdef TMR_EXPIRY_LATENCY_EN
  logic [31:0] late1, late2;
  logic        lflag1, lflag2;
`endif
  timer_expiry_queue_if #(.C_ADDRESS_WIDTH(32), .C_TICK_WIDTH(32)) evt1 ();

  timer_expiry_queue u_dut1 (
    .aclk          (aclk),
    .areset        (areset),
    .expire_in     (expire1),
    .expPointer_in (ptr1),
    .tick_in       (tick1),
    .flush_in      (flush1),
    .ovfClr_in     (clr1),
    .evt           (evt1),
`ifdef TMR_EXPIRY_LATENCY_EN
    .evtLate_out   (late1),
    .lateFlag_out  (lflag1),
`endif
    .count_out     (count1),
    .irq_out       (irq1),
    .ovf_out       (ovf1),
    .dropCnt_out   (drop1)
  );

  // dut2: DEPTH 4, THRESH 4, DROP 2
  logic        expire2 = 1'b0, flush2 = 1'b0, clr2 = 1'b0;
  logic [31:0] ptr2 = 32'h0, tick2 = 32'h0;
  logic [2:0]  count2;
  logic        irq2, ovf2;
  logic [1:0]  drop2;
  timer_expiry_queue_if #(.C_ADDRESS_WIDTH(32), .C_TICK_WIDTH(32)) evt2 ();

  timer_expiry_queue #(
    .C_DEPTH      (4),
    .C_IRQ_THRESH (4),
    .C_DROP_WIDTH (2)
  ) u_dut2 (
    .aclk          (aclk),
    .areset        (areset),
    .expire_in     (expire2),
    .expPointer_in (ptr2),
    .tick_in       (tick2),
    .flush_in      (flush2),
    .ovfClr_in     (clr2),
    .evt           (evt2),
`ifdef TMR_EXPIRY_LATENCY_EN
    .evtLate_out   (late2),
    .lateFlag_out  (lflag2),
`endif
    .count_out     (count2),
    .irq_out       (irq2),
    .ovf_out       (ovf2),
    .dropCnt_out   (drop2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    evt1.evtReady_in = 1'b0;
    evt2.evtReady_in = 1'b0;
    step();
    step();
    check("rst_valid", 64'(evt1.evtValid_out), 64'd0);
    check("rst_count", 64'(count1), 64'd0);
    check("rst_irq",   64'(irq1), 64'd0);
    check("rst_ovf",   64'(ovf1), 64'd0);
    check("rst_drop",  64'(drop1), 64'd0);
    areset = 1'b0;
    step();

    // Single push becomes visible one cycle later
    expire1 = 1'b1; ptr1 = 32'h1000; tick1 = 32'd5;
    step();
    expire1 = 1'b0;
    check("t1_valid", 64'(evt1.evtValid_out), 64'd1);
    check("t1_ptr",   64'(evt1.evtPointer_out), 64'h1000);
    check("t1_tick",  64'(evt1.evtTick_out), 64'd5);
    check("t1_count", 64'(count1), 64'd1);
    check("t1_irq",   64'(irq1), 64'd1);

    // Fill to 16 with ready low
    for (int i = 1; i < 16; i++) begin
      expire1 = 1'b1; ptr1 = 32'h1000 + 32'(i); tick1 = 32'd100 + 32'(i);
      step();
    end
    expire1 = 1'b0;
    check("fill_count", 64'(count1), 64'd16);
    check("fill_ovf",   64'(ovf1), 64'd0);

    // 17th push is dropped
    expire1 = 1'b1; ptr1 = 32'hDEAD;
    step();
    check("drop1_ovf",   64'(ovf1), 64'd1);
    check("drop1_cnt",   64'(drop1), 64'd1);
    check("drop1_count", 64'(count1), 64'd16);
    check("drop1_head",  64'(evt1.evtPointer_out), 64'h1000);
    step();
    check("drop2_cnt", 64'(drop1), 64'd2);
    // Drop and clear together: drop wins, counter restarts at 1
    clr1 = 1'b1;
    step();
    check("dropclr_ovf", 64'(ovf1), 64'd1);
    check("dropclr_cnt", 64'(drop1), 64'd1);
    expire1 = 1'b0;
    step();
    clr1 = 1'b0;
    check("clr_ovf", 64'(ovf1), 64'd0);
    check("clr_cnt", 64'(drop1), 64'd0);

    // Full with pop and push together
    expire1 = 1'b1; ptr1 = 32'h2000; tick1 = 32'd200; evt1.evtReady_in = 1'b1;
    step();
    expire1 = 1'b0; evt1.evtReady_in = 1'b0;
    check("pp_count", 64'(count1), 64'd16);
    check("pp_ovf",   64'(ovf1), 64'd0);
    check("pp_drop",  64'(drop1), 64'd0);

    // Drain across the pointer wrap
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain_ptr%0d", i), 64'(evt1.evtPointer_out),
            (i == 16) ? 64'h2000 : 64'h1000 + 64'(i));
      evt1.evtReady_in = 1'b1;
      step();
    end
    evt1.evtReady_in = 1'b0;
    check("drain_count", 64'(count1), 64'd0);
    check("drain_valid", 64'(evt1.evtValid_out), 64'd0);
    check("drain_irq",   64'(irq1), 64'd0);

    // Flush with a coinciding push
    for (int i = 0; i < 3; i++) begin
      expire1 = 1'b1; ptr1 = 32'h5000 + 32'(i);
      step();
    end
    check("pre_flush_count", 64'(count1), 64'd3);
    flush1 = 1'b1; ptr1 = 32'h5555;
    step();
    flush1 = 1'b0; expire1 = 1'b0;
    check("flush_count", 64'(count1), 64'd0);
    check("flush_valid", 64'(evt1.evtValid_out), 64'd0);
    check("flush_drop",  64'(drop1), 64'd0);
    check("flush_irq",   64'(irq1), 64'd0);
    expire1 = 1'b1; ptr1 = 32'h3000; tick1 = 32'd7;
    step();
    expire1 = 1'b0;
    check("post_flush_ptr",  64'(evt1.evtPointer_out), 64'h3000);
    check("post_flush_tick", 64'(evt1.evtTick_out), 64'd7);
    check("post_flush_cnt",  64'(count1), 64'd1);
    evt1.evtReady_in = 1'b1;
    step();
    evt1.evtReady_in = 1'b0;
    check("post_flush_pop", 64'(evt1.evtValid_out), 64'd0);

`ifdef TMR_EXPIRY_LATENCY_EN
    // Latency across tick wrap
    expire1 = 1'b1; ptr1 = 32'h4000; tick1 = 32'hFFFF_FFFE;
    step();
    expire1 = 1'b0; tick1 = 32'h3;
    #1;
    check("late_value",   64'(late1), 64'd5);
    check("late_pre_pop", 64'(lflag1), 64'd0);
    evt1.evtReady_in = 1'b1;
    step();
    evt1.evtReady_in = 1'b0;
    check("late_flag", 64'(lflag1), 64'd1);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    check("late_clr", 64'(lflag1), 64'd0);
`endif

    // IRQ threshold 4 on dut2
    for (int i = 0; i < 3; i++) begin
      expire2 = 1'b1; ptr2 = 32'hA0 + 32'(i);
      step();
    end
    expire2 = 1'b0;
    check("thr_count3", 64'(count2), 64'd3);
    check("thr_irq3",   64'(irq2), 64'd0);
    expire2 = 1'b1; ptr2 = 32'hA3;
    step();
    expire2 = 1'b0;
    check("thr_irq4", 64'(irq2), 64'd1);
    evt2.evtReady_in = 1'b1;
    step();
    evt2.evtReady_in = 1'b0;
    check("thr_pop_count", 64'(count2), 64'd3);
    check("thr_pop_irq",   64'(irq2), 64'd0);
    check("thr_pop_head",  64'(evt2.evtPointer_out), 64'hA1);

    // Refill then saturate the 2-bit drop counter
    expire2 = 1'b1; ptr2 = 32'hA4;
    step();
    check("sat_full_irq", 64'(irq2), 64'd1);
    ptr2 = 32'hBAD;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    expire2 = 1'b0;
    check("sat_drop",  64'(drop2), 64'd3);
    check("sat_ovf",   64'(ovf2), 64'd1);
    check("sat_count", 64'(count2), 64'd4);
    check("sat_head",  64'(evt2.evtPointer_out), 64'hA1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
